controlador_exibicao_rgb: RTL
=============================

# controlador_exibicao_rgb

Sequencer for the memory-game RGB LED. On a start pulse it walks the stored color sequence from address 0 up to a programmable last address. It presents each one-hot color word to the RGB decoder for a fixed lit interval, then blanks the LED for a fixed dark interval. It sits between the sequence memory and the RGB decoder and owns the decoder's enable and data inputs.

## Interface
- T_ACESO, 50_000_000: lit interval per item, in clock cycles (≥1)
- T_APAGADO, 25_000_000: dark interval per item, in clock cycles (≥1)
- ADDR_W, 4: sequence memory address width
- clock  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- iniciar  in  1  start request; sampled only in OCIOSO
- limite  in  ADDR_W  index of the last item to show; sampled at start
- dados_mem  in  4  one-hot color word; combinational read of `endereco`
- endereco  out  ADDR_W  sequence memory address
- en_rgb  out  1  decoder enable
- dados_rgb  out  4  decoder data, latched copy of `dados_mem`
- ocupado  out  1  high in every state except OCIOSO
- pronto  out  1  one-cycle pulse when the sequence ends
- pausa  in  1  exists only with EXIBE_PAUSA_EN

## Operation
- Reset values: state OCIOSO, endereco=0, en_rgb=0, dados_rgb=0, ocupado=0, pronto=0, timer=0, latched limite=0.
- OCIOSO → CARREGA when iniciar=1: latch limite, endereco=0, ocupado=1.
- CARREGA, 1 cycle: latch dados_mem into dados_rgb, load timer with T_ACESO-1, then go to ACESO.
- ACESO: en_rgb=1. The timer decrements every cycle. At 0, load timer with T_APAGADO-1 and go to APAGADO.
- APAGADO: en_rgb=0, dados_rgb held. The timer decrements every cycle. At 0:
  - if endereco==latched limite, go to FIM;
  - otherwise endereco+1, go to CARREGA.
- FIM, 1 cycle: pronto=1, endereco=0, dados_rgb=0, then go to OCIOSO.
- iniciar is ignored outside OCIOSO. A change to limite after start has no effect.
- dados_mem is passed through unchecked. Non-one-hot words are blanked by the decoder; this block still spends the full T_ACESO+T_APAGADO on them.
- Address wrap: limite = 2^ADDR_W−1 shows all entries. endereco never increments past limite, so it never wraps.
- Reset mid-operation: the next edge forces OCIOSO with reset values. No pronto pulse is issued.
- iniciar=1 during the FIM cycle is ignored. It is sampled again once the block is in OCIOSO.

## Timing
- Edge 0 samples iniciar=1. The block is in CARREGA during cycle 1. en_rgb rises at the start of cycle 2.
- Per item: 1 (CARREGA) + T_ACESO + T_APAGADO cycles. en_rgb is high for exactly T_ACESO consecutive cycles per item.
- pronto is high in cycle (limite+1)·(1+T_ACESO+T_APAGADO)+1 after edge 0. ocupado falls in the following cycle.
- All outputs are registered (Moore). No combinational path from any input to any output.
- Timer width is $clog2(max(T_ACESO,T_APAGADO)).

## Configuration
- EXIBE_PAUSA_EN defined:
  - the `pausa` port exists;
  - pausa=1 in ACESO or APAGADO freezes the timer, state, endereco, en_rgb and dados_rgb;
  - pausa is ignored in other states;
  - the remaining interval resumes exactly on release.
- EXIBE_PAUSA_EN undefined: no pausa port and no pause logic. Timing is exactly as above.

## Structure
- Shared package holds:
  - state encoding constants OCIOSO, CARREGA, ACESO, APAGADO, FIM (3-bit);
  - default T_ACESO / T_APAGADO values;
  - the one-hot color constants (vermelho 0001, azul 0010, amarelo 0100, verde 1000), also used by the memory and the decoder.
- Natural sub-module: `contador_tempo`, a down-counter with load value, load, enable (tied to pause) and zero flag.
- The RGB decoder is instantiated by the parent, not inside this block.

## Test plan
Parameters for scenarios 1–5: T_ACESO=3, T_APAGADO=2, ADDR_W=4.
1. Reset → all outputs 0. Hold reset 3 cycles with iniciar=1 → state stays OCIOSO, no en_rgb.
2. Memory {0001,0010,0100}, limite=2, iniciar pulse at edge 0:
   - en_rgb high in cycles 2–4 (dados_rgb=0001), 8–10 (0010) and 14–16 (0100);
   - pronto in cycle 19 only;
   - endereco sequence 0,1,2.
3. limite=0, memory[0]=1000 → single 3-cycle lit burst; pronto in cycle 7.
4. Reset in cycle 9 of scenario 2 → outputs 0 at the next edge, no pronto. A new iniciar restarts from address 0.
5. iniciar re-pulsed in cycles 5 and 19 of scenario 2 → ignored; ocupado stays 1, timing unchanged.
6. With EXIBE_PAUSA_EN: pausa=1 for 4 cycles in cycle 3 of scenario 2 → first lit interval stretched to 7 cycles; pronto moves to cycle 23.

Source files
------------

// File: rtl/controlador_exibicao_rgb_pkg.sv
// Shared definitions for the memory-game RGB display path: FSM states, default
// intervals, one-hot color words and the interval-timer width helper.
package controlador_exibicao_rgb_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam int unsigned T_ACESO_PADRAO   = 50_000_000;
  localparam int unsigned T_APAGADO_PADRAO = 25_000_000;

  localparam logic [3:0] COR_VERMELHO = 4'b0001;
  localparam logic [3:0] COR_AZUL     = 4'b0010;
  localparam logic [3:0] COR_AMARELO  = 4'b0100;
  localparam logic [3:0] COR_VERDE    = 4'b1000;

  // Timer only ever holds interval-1, so clog2 of the longer interval suffices.
  function automatic int unsigned larg_timer(input int unsigned ta, input int unsigned td);
    int unsigned m;
    m = (ta > td) ? ta : td;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/controlador_exibicao_rgb_tempo.sv
// Interval down-counter: loads a value, counts down while enabled, flags zero.
module contador_tempo
  import controlador_exibicao_rgb_pkg::*;
#(
  parameter int unsigned LARG = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_carga,
  input  logic [LARG-1:0] i_valor,
  input  logic            i_habilita,
  output logic            o_zero_c
);

  logic [LARG-1:0] r_cont;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cont <= '0;
    end else if (i_carga) begin
      r_cont <= i_valor;
    end else if (i_habilita && (r_cont != '0)) begin
      r_cont <= r_cont - LARG'(1);
    end
  end

  assign o_zero_c = (r_cont == '0);

endmodule

// File: rtl/controlador_exibicao_rgb.sv
// Walks the stored color sequence 0..limite, lighting each entry for T_ACESO
// cycles then blanking for T_APAGADO. Optional freeze input under EXIBE_PAUSA_EN.
module controlador_exibicao_rgb
  import controlador_exibicao_rgb_pkg::*;
#(
  parameter int unsigned T_ACESO   = T_ACESO_PADRAO,
  parameter int unsigned T_APAGADO = T_APAGADO_PADRAO,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_iniciar,
  input  logic [ADDR_W-1:0] i_limite,
  input  logic [3:0]        i_dados_mem,
`ifdef EXIBE_PAUSA_EN
  input  logic              i_pausa,
`endif
  output logic [ADDR_W-1:0] o_endereco,
  output logic              o_en_rgb,
  output logic [3:0]        o_dados_rgb,
  output logic              o_ocupado,
  output logic              o_pronto
);

  localparam int unsigned TW = larg_timer(T_ACESO, T_APAGADO);

  estado_t           r_estado, w_estado_prox;
  logic [ADDR_W-1:0] r_limite, r_endereco;
  logic [3:0]        r_dados_rgb;
  logic              r_en_rgb, r_ocupado, r_pronto;
  logic              w_avanca, w_carga, w_habilita, w_incrementa, w_zero;
  logic [TW-1:0]     w_valor_carga;

`ifdef EXIBE_PAUSA_EN
  assign w_avanca = !i_pausa;
`else
  assign w_avanca = 1'b1;
`endif

  contador_tempo #(.LARG(TW)) u_tempo (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_carga    (w_carga),
    .i_valor    (w_valor_carga),
    .i_habilita (w_habilita),
    .o_zero_c   (w_zero)
  );

  // Next state and timer control; pause only holds the lit/dark states.
  always_comb begin
    w_estado_prox = r_estado;
    w_carga       = 1'b0;
    w_valor_carga = TW'(T_ACESO - 1);
    w_habilita    = 1'b0;
    w_incrementa  = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (i_iniciar) w_estado_prox = CARREGA;
      end
      CARREGA: begin
        w_carga       = 1'b1;
        w_valor_carga = TW'(T_ACESO - 1);
        w_estado_prox = ACESO;
      end
      ACESO: begin
        w_habilita = w_avanca;
        if (w_avanca && w_zero) begin
          w_carga       = 1'b1;
          w_valor_carga = TW'(T_APAGADO - 1);
          w_estado_prox = APAGADO;
        end
      end
      APAGADO: begin
        w_habilita = w_avanca;
        if (w_avanca && w_zero) begin
          if (r_endereco == r_limite) begin
            w_estado_prox = FIM;
          end else begin
            w_incrementa  = 1'b1;
            w_estado_prox = CARREGA;
          end
        end
      end
      FIM:     w_estado_prox = OCIOSO;
      default: w_estado_prox = OCIOSO;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_estado    <= OCIOSO;
      r_limite    <= '0;
      r_endereco  <= '0;
      r_dados_rgb <= '0;
      r_en_rgb    <= 1'b0;
      r_ocupado   <= 1'b0;
      r_pronto    <= 1'b0;
    end else begin
      r_estado  <= w_estado_prox;
      r_en_rgb  <= (w_estado_prox == ACESO);
      r_ocupado <= (w_estado_prox != OCIOSO);
      r_pronto  <= (w_estado_prox == FIM);
      if ((r_estado == OCIOSO) && i_iniciar) begin
        r_limite   <= i_limite;
        r_endereco <= '0;
      end
      if (r_estado == CARREGA) r_dados_rgb <= i_dados_mem;
      if (w_incrementa) r_endereco <= r_endereco + ADDR_W'(1);
      if (w_estado_prox == FIM) begin
        r_endereco  <= '0;
        r_dados_rgb <= '0;
      end
    end
  end

  assign o_endereco  = r_endereco;
  assign o_en_rgb    = r_en_rgb;
  assign o_dados_rgb = r_dados_rgb;
  assign o_ocupado   = r_ocupado;
  assign o_pronto    = r_pronto;

endmodule
